// File: rtl/cpu_register_bank.sv
// cpu_register_bank
// Holds AR, PC, DR, AC, IR, TR and the E flag, plus the AC/E arithmetic-logic
// unit. The common bus value is the only load source. All state updates happen
// on the rising clock edge. Reset is asynchronous and active-low.
module cpu_register_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_in,
  input  logic [5:0]       ld,
  input  logic [5:0]       inr,
  input  logic [5:0]       clr,
  input  logic             alu_en,
  input  logic [2:0]       alu_op,
  input  logic             e_clr,
  input  logic             e_cmp,
  output logic [WIDTH-1:0] ar_q,
  output logic [WIDTH-1:0] pc_q,
  output logic [WIDTH-1:0] dr_q,
  output logic [WIDTH-1:0] ac_q,
  output logic [WIDTH-1:0] ir_q,
  output logic [WIDTH-1:0] tr_q,
  output logic             e_q,
  output logic             ac_zero,
  output logic             dr_zero
);

  // Register indices shared by the ld/inr/clr strobe vectors.
  localparam int IDX_AR = 0;
  localparam int IDX_PC = 1;
  localparam int IDX_DR = 2;
  localparam int IDX_AC = 3;
  localparam int IDX_IR = 4;
  localparam int IDX_TR = 5;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  typedef enum logic [2:0] {
    OP_NONE0 = 3'b000,
    OP_AND   = 3'b001,
    OP_ADD   = 3'b010,
    OP_LDA   = 3'b011,
    OP_CMA   = 3'b100,
    OP_CIR   = 3'b101,
    OP_CIL   = 3'b110,
    OP_NONE7 = 3'b111
  } alu_op_t;

  // Current contents of all six registers, indexed like the strobes.
  logic [WIDTH-1:0] reg_q [6];

  // AC and E state.
  logic [WIDTH-1:0] ac_reg;
  logic [WIDTH-1:0] ac_next;
  logic             e_reg;
  logic             e_next;

  // ALU datapath.
  alu_op_t          op;
  logic             alu_sel;
  logic [WIDTH-1:0] alu_res;
  logic             alu_e_val;
  logic             alu_e_upd;
  logic [WIDTH:0]   add_sum;
  logic             e_from_alu;

  // Plain registers (all but AC) share one clear > load > increment scheme;
  // AC is wired in separately because the ALU sits in its priority chain.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_reg
      if (gi == IDX_AC) begin : g_ac
        assign reg_q[gi] = ac_reg;
      end else begin : g_plain
        logic [WIDTH-1:0] r_reg;

        // Clear beats load beats increment; increment wraps modulo 2^WIDTH.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_reg <= ZERO;
          end else if (clr[gi]) begin
            r_reg <= ZERO;
          end else if (ld[gi]) begin
            r_reg <= bus_in;
          end else if (inr[gi]) begin
            r_reg <= r_reg + ONE;
          end
        end

        assign reg_q[gi] = r_reg;
      end
    end
  endgenerate

  assign op      = alu_op_t'(alu_op);
  assign add_sum = {1'b0, ac_reg} + {1'b0, reg_q[IDX_DR]};

  // ALU result and its E side effect; ops 000/111 leave alu_sel low so an
  // increment strobe on AC can still take effect.
  always_comb begin
    alu_res   = ac_reg;
    alu_e_val = e_reg;
    alu_e_upd = 1'b0;
    alu_sel   = 1'b0;
    case (op)
      OP_AND: begin
        alu_sel = alu_en;
        alu_res = ac_reg & reg_q[IDX_DR];
      end
      OP_ADD: begin
        alu_sel   = alu_en;
        alu_res   = add_sum[WIDTH-1:0];
        alu_e_val = add_sum[WIDTH];
        alu_e_upd = 1'b1;
      end
      OP_LDA: begin
        alu_sel = alu_en;
        alu_res = reg_q[IDX_DR];
      end
      OP_CMA: begin
        alu_sel = alu_en;
        alu_res = ~ac_reg;
      end
      OP_CIR: begin
        alu_sel   = alu_en;
        alu_res   = {e_reg, ac_reg[WIDTH-1:1]};
        alu_e_val = ac_reg[0];
        alu_e_upd = 1'b1;
      end
      OP_CIL: begin
        alu_sel   = alu_en;
        alu_res   = {ac_reg[WIDTH-2:0], e_reg};
        alu_e_val = ac_reg[WIDTH-1];
        alu_e_upd = 1'b1;
      end
      default: begin
        alu_sel = 1'b0;
      end
    endcase
  end

  // AC next value: clear > load > ALU > increment > hold. The ALU's E effect
  // only survives when the ALU actually wins the AC update.
  always_comb begin
    ac_next    = ac_reg;
    e_from_alu = 1'b0;
    if (clr[IDX_AC]) begin
      ac_next = ZERO;
    end else if (ld[IDX_AC]) begin
      ac_next = bus_in;
    end else if (alu_sel) begin
      ac_next    = alu_res;
      e_from_alu = alu_e_upd;
    end else if (inr[IDX_AC]) begin
      ac_next = ac_reg + ONE;
    end
  end

  // E next value: explicit clear > complement > ALU carry/rotate > hold.
  always_comb begin
    e_next = e_reg;
    if (e_clr) begin
      e_next = 1'b0;
    end else if (e_cmp) begin
      e_next = ~e_reg;
    end else if (e_from_alu) begin
      e_next = alu_e_val;
    end
  end

  // AC and E state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac_reg <= ZERO;
      e_reg  <= 1'b0;
    end else begin
      ac_reg <= ac_next;
      e_reg  <= e_next;
    end
  end

  assign ar_q    = reg_q[IDX_AR];
  assign pc_q    = reg_q[IDX_PC];
  assign dr_q    = reg_q[IDX_DR];
  assign ac_q    = reg_q[IDX_AC];
  assign ir_q    = reg_q[IDX_IR];
  assign tr_q    = reg_q[IDX_TR];
  assign e_q     = e_reg;
  assign ac_zero = (ac_reg == ZERO);
  assign dr_zero = (reg_q[IDX_DR] == ZERO);

endmodule

// File: tb/tb_cpu_register_bank.sv
// Directed scoreboard bench for cpu_register_bank: the stimulus process queues
// hand-computed expectations after each operation, and a monitor process
// checks them on the following falling edge.
module tb_cpu_register_bank;

  logic       clk;
  logic       rst_n;
  logic [7:0] bus_in;
  logic [5:0] ld;
  logic [5:0] inr;
  logic [5:0] clr;
  logic       alu_en;
  logic [2:0] alu_op;
  logic       e_clr;
  logic       e_cmp;
  logic [7:0] ar_q, pc_q, dr_q, ac_q, ir_q, tr_q;
  logic       e_q, ac_zero, dr_zero;

  cpu_register_bank #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in),
    .ld(ld), .inr(inr), .clr(clr),
    .alu_en(alu_en), .alu_op(alu_op),
    .e_clr(e_clr), .e_cmp(e_cmp),
    .ar_q(ar_q), .pc_q(pc_q), .dr_q(dr_q), .ac_q(ac_q), .ir_q(ir_q), .tr_q(tr_q),
    .e_q(e_q), .ac_zero(ac_zero), .dr_zero(dr_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed item selectors.
  localparam int S_AR = 0, S_PC = 1, S_DR = 2, S_AC = 3, S_IR = 4, S_TR = 5;
  localparam int S_E = 6, S_ACZ = 7, S_DRZ = 8;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      S_AR:    return ar_q;
      S_PC:    return pc_q;
      S_DR:    return dr_q;
      S_AC:    return ac_q;
      S_IR:    return ir_q;
      S_TR:    return tr_q;
      S_E:     return {7'd0, e_q};
      S_ACZ:   return {7'd0, ac_zero};
      default: return {7'd0, dr_zero};
    endcase
  endfunction

  // Monitor: outputs are stable away from the rising edge, so drain the
  // scoreboard on each falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e   = exp_q.pop_front();
      act = observe(e.sel);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, act, e.exp);
      end else begin
        $display("ok   %s: 0x%02h", e.name, act);
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [7:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    bus_in = 8'h00; ld = '0; inr = '0; clr = '0;
    alu_en = 1'b0; alu_op = 3'b000; e_clr = 1'b0; e_cmp = 1'b0;
  endtask

  // One operation cycle: drive on the falling edge, let the rising edge act,
  // then release the strobes just after it.
  task automatic op_cycle(input logic [5:0] l, input logic [5:0] i, input logic [5:0] c,
                          input logic [7:0] b, input logic ae, input logic [2:0] op,
                          input logic ec, input logic ecm);
    @(negedge clk);
    bus_in = b; ld = l; inr = i; clr = c;
    alu_en = ae; alu_op = op; e_clr = ec; e_cmp = ecm;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic load(input logic [5:0] l, input logic [7:0] b);
    op_cycle(l, 6'd0, 6'd0, b, 1'b0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic alu(input logic [2:0] op, input logic ec);
    op_cycle(6'd0, 6'd0, 6'd0, 8'h00, 1'b1, op, ec, 1'b0);
  endtask

  task automatic expect_all(input string tag, input logic [7:0] v);
    expect_val({tag, " ar"}, S_AR, v);
    expect_val({tag, " pc"}, S_PC, v);
    expect_val({tag, " dr"}, S_DR, v);
    expect_val({tag, " ac"}, S_AC, v);
    expect_val({tag, " ir"}, S_IR, v);
    expect_val({tag, " tr"}, S_TR, v);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #2;
    expect_all("reset", 8'h00);
    expect_val("reset e", S_E, 8'h00);
    expect_val("reset ac_zero", S_ACZ, 8'h01);
    expect_val("reset dr_zero", S_DRZ, 8'h01);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Load everything, then assert reset between edges.
    load(6'h3F, 8'h5A);
    expect_all("ld all", 8'h5A);
    expect_val("ld all ac_zero", S_ACZ, 8'h00);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expect_all("async rst", 8'h00);
    expect_val("async rst e", S_E, 8'h00);
    expect_val("async rst ac_zero", S_ACZ, 8'h01);
    @(negedge clk);
    rst_n = 1'b1;

    // PC wrap and strobe priority.
    load(6'b000010, 8'hFF);
    expect_val("pc ld ff", S_PC, 8'hFF);
    op_cycle(6'd0, 6'b000010, 6'd0, 8'h00, 1'b0, 3'b000, 1'b0, 1'b0);
    expect_val("pc inr wrap", S_PC, 8'h00);
    op_cycle(6'b000010, 6'b000010, 6'd0, 8'h10, 1'b0, 3'b000, 1'b0, 1'b0);
    expect_val("pc ld over inr", S_PC, 8'h10);
    op_cycle(6'b000010, 6'd0, 6'b000010, 8'h33, 1'b0, 3'b000, 1'b0, 1'b0);
    expect_val("pc clr over ld", S_PC, 8'h00);

    // ADD with carry, then again with e_clr overriding the carry.
    load(6'b001000, 8'hF0);
    load(6'b000100, 8'h20);
    alu(3'b010, 1'b0);
    expect_val("add ac", S_AC, 8'h10);
    expect_val("add e", S_E, 8'h01);
    load(6'b001000, 8'hF0);
    alu(3'b010, 1'b1);
    expect_val("add eclr ac", S_AC, 8'h10);
    expect_val("add eclr e", S_E, 8'h00);

    // Rotates through E.
    load(6'b001000, 8'h81);
    alu(3'b110, 1'b0);
    expect_val("cil ac", S_AC, 8'h02);
    expect_val("cil e", S_E, 8'h01);
    alu(3'b101, 1'b0);
    expect_val("cir ac", S_AC, 8'h81);
    expect_val("cir e", S_E, 8'h00);

    // Logic ops and LDA.
    load(6'b001000, 8'hCC);
    load(6'b000100, 8'hAA);
    alu(3'b001, 1'b0);
    expect_val("and ac", S_AC, 8'h88);
    alu(3'b100, 1'b0);
    expect_val("cma ac", S_AC, 8'h77);
    alu(3'b011, 1'b0);
    expect_val("lda ac", S_AC, 8'hAA);
    expect_val("lda e", S_E, 8'h00);
    op_cycle(6'd0, 6'd0, 6'b000100, 8'h00, 1'b0, 3'b000, 1'b0, 1'b0);
    expect_val("dr clr", S_DR, 8'h00);
    expect_val("dr_zero", S_DRZ, 8'h01);

    // Fetch overlap: AR <- bus while PC increments.
    load(6'b000010, 8'h05);
    op_cycle(6'b000001, 6'b000010, 6'd0, 8'h05, 1'b0, 3'b000, 1'b0, 1'b0);
    expect_val("fetch ar", S_AR, 8'h05);
    expect_val("fetch pc", S_PC, 8'h06);

    // Set E, then load AC while ADD is requested: load wins, E untouched.
    op_cycle(6'd0, 6'd0, 6'd0, 8'h00, 1'b0, 3'b000, 1'b0, 1'b1);
    expect_val("ecmp e", S_E, 8'h01);
    op_cycle(6'b001000, 6'd0, 6'd0, 8'h3C, 1'b1, 3'b010, 1'b0, 1'b0);
    expect_val("ld over add ac", S_AC, 8'h3C);
    expect_val("ld over add e", S_E, 8'h01);

    // Null ALU ops let increment through; a real op beats increment.
    op_cycle(6'd0, 6'b001000, 6'd0, 8'h00, 1'b1, 3'b000, 1'b0, 1'b0);
    expect_val("op0 inr ac", S_AC, 8'h3D);
    op_cycle(6'd0, 6'b001000, 6'd0, 8'h00, 1'b1, 3'b111, 1'b0, 1'b0);
    expect_val("op7 inr ac", S_AC, 8'h3E);
    load(6'b001000, 8'hFF);
    op_cycle(6'd0, 6'b001000, 6'd0, 8'h00, 1'b1, 3'b010, 1'b0, 1'b0);
    expect_val("add over inr ac", S_AC, 8'hFF);
    expect_val("add over inr e", S_E, 8'h00);
    op_cycle(6'd0, 6'b001000, 6'd0, 8'h00, 1'b0, 3'b000, 1'b0, 1'b0);
    expect_val("ac inr wrap", S_AC, 8'h00);
    expect_val("ac inr wrap zero", S_ACZ, 8'h01);
    expect_val("ac inr e", S_E, 8'h00);

    // Bounded drain of the scoreboard.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
